// File: rtl/pipe_cla_adder_pkg.sv
// Shared defaults and operation encoding for the pipelined lookahead adder.
package pipe_cla_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;
  localparam int DEF_GROUP  = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/pipe_cla_adder_cla_slice.sv
// Combinational carry-lookahead adder for one pipeline slice: sum-of-products
// carries inside each GROUP-bit group, group carries chained slice-wide.
module cla_slice #(
  parameter int SLICE_W = 16,
  parameter int GROUP   = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int NGRP = SLICE_W / GROUP;

  if (GROUP < 1 || SLICE_W < GROUP || (SLICE_W % GROUP) != 0) begin : g_bad_param
    $error("cla_slice: SLICE_W must be a positive multiple of GROUP");
  end

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [GROUP-1:0]   pp;
  logic [GROUP:0]     gx;
  logic [GROUP:0]     cc;
  logic               term;
  logic               gcar;

  assign g = a & b;
  assign p = a ^ b;

  // gx[0] is the group carry-in, gx[i] is generate of bit i-1; carry j is the
  // OR over i<=j of gx[i] propagated through p[i..j-1].
  always_comb begin
    sum  = '0;
    gcar = cin;
    pp   = '0;
    gx   = '0;
    cc   = '0;
    term = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      pp = p[k*GROUP +: GROUP];
      gx = {g[k*GROUP +: GROUP], gcar};
      for (int j = 0; j <= GROUP; j++) begin
        cc[j] = 1'b0;
        for (int i = 0; i <= j; i++) begin
          term = gx[i];
          for (int m = i; m < j; m++) begin
            term = term & pp[m];
          end
          cc[j] = cc[j] | term;
        end
      end
      sum[k*GROUP +: GROUP] = pp ^ cc[GROUP-1:0];
      gcar = cc[GROUP];
    end
  end

  assign cout = gcar;

endmodule

// File: rtl/pipe_cla_adder.sv
// Add/subtract pipeline: stage s sums operand slice s, later slices and earlier
// results ride along in the stage registers; valid/ready flow with bubble collapse.
module pipe_cla_adder
  import pipe_cla_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int GROUP  = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE_W = WIDTH / STAGES;
  localparam int LAST    = STAGES - 1;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0 || GROUP < 1 ||
      (SLICE_W % GROUP) != 0) begin : g_bad_param
    $error("pipe_cla_adder: illegal WIDTH/STAGES/GROUP combination");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] can_load;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] slice_cout;
  logic [WIDTH-1:0]  a_q      [STAGES];
  logic [WIDTH-1:0]  b_q      [STAGES];
  logic [WIDTH-1:0]  s_q      [STAGES];
  logic [WIDTH-1:0]  op_a     [STAGES];
  logic [WIDTH-1:0]  op_b     [STAGES];
  logic [WIDTH-1:0]  nxt_sum  [STAGES];
  logic              ovf_q;
  logic              zero_q;
  logic              ovf_nxt;
  logic              zero_nxt;

  assign mode  = mode_e'(sub);
  assign b_eff = (mode == MODE_SUB) ? ~b : b;

  // A stage can take a new beat when it is empty or its content moves on;
  // evaluated from the output end so bubbles anywhere let upstream advance.
  always_comb begin
    can_load       = '0;
    can_load[LAST] = !vld[LAST] || out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      can_load[s] = !vld[s] || can_load[s+1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0]   part;
    logic               carry_in;
    logic [SLICE_W-1:0] slice_sum;
    logic [WIDTH-1:0]   merged;

    if (s == 0) begin : g_first
      assign op_a[s]     = a;
      assign op_b[s]     = b_eff;
      assign part        = '0;
      assign carry_in    = cin ^ sub;
      assign up_valid[s] = in_valid;
    end else begin : g_rest
      assign op_a[s]     = a_q[s-1];
      assign op_b[s]     = b_q[s-1];
      assign part        = s_q[s-1];
      assign carry_in    = c_q[s-1];
      assign up_valid[s] = vld[s-1];
    end

    cla_slice #(
      .SLICE_W(SLICE_W),
      .GROUP  (GROUP)
    ) u_slice (
      .a   (op_a[s][s*SLICE_W +: SLICE_W]),
      .b   (op_b[s][s*SLICE_W +: SLICE_W]),
      .cin (carry_in),
      .sum (slice_sum),
      .cout(slice_cout[s])
    );

    always_comb begin
      merged                       = part;
      merged[s*SLICE_W +: SLICE_W] = slice_sum;
    end

    assign nxt_sum[s] = merged;
  end

  assign ovf_nxt  = (op_a[LAST][WIDTH-1] == op_b[LAST][WIDTH-1]) &&
                    (nxt_sum[LAST][WIDTH-1] != op_a[LAST][WIDTH-1]);
  assign zero_nxt = ~|nxt_sum[LAST];

  // Stage registers; a stalled last stage keeps its result and flags untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (can_load[s]) begin
          vld[s] <= up_valid[s];
          if (up_valid[s]) begin
            a_q[s] <= op_a[s];
            b_q[s] <= op_b[s];
            s_q[s] <= nxt_sum[s];
            c_q[s] <= slice_cout[s];
          end
        end
      end
      if (can_load[LAST] && up_valid[LAST]) begin
        ovf_q  <= ovf_nxt;
        zero_q <= zero_nxt;
      end
    end
  end

  assign in_ready  = can_load[0];
  assign out_valid = vld[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, STAGES=2, GROUP=4) against an
// integer-arithmetic reference model and an in-order expected-result queue.
module tb_pipe_cla_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int GROUP  = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int   vectors     = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipe_cla_adder #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .GROUP (GROUP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  // Reference: unsigned sum for result/carry, signed range test for overflow.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    longint modv, ux, uy, uc, full, sx, sy, sres;
    res_t   r;
    modv = longint'(1) << WIDTH;
    ux   = longint'(x);
    uy   = s ? (modv - 1 - longint'(y)) : longint'(y);
    uc   = longint'(c ^ s);
    full = ux + uy + uc;
    sx   = (ux >= modv / 2) ? ux - modv : ux;
    sy   = (uy >= modv / 2) ? uy - modv : uy;
    sres = sx + sy + uc;
    r.sum  = WIDTH'(full % modv);
    r.cout = (full >= modv);
    r.ovf  = (sres > modv / 2 - 1) || (sres < -(modv / 2));
    r.zero = ((full % modv) == 0);
    return r;
  endfunction

  // Drives one cycle's inputs at the falling edge and reports the handshakes
  // that will complete on the following rising edge.
  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] ia,
                             input logic [WIDTH-1:0] ib, input logic ic, input logic is,
                             input logic ordy, output logic acc, output logic emit);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    vectors++;
    if ({sum, cout, ovf, zero} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h/%b/%b/%b, want 0", sum, cout, ovf, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release_state: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] ta[4];
    logic [WIDTH-1:0] tb[4];
    logic             tc[4];
    logic             ts[4];
    res_t             texp[4];
    res_t             got;
    logic             acc, emit;
    int               lat;
    ta = '{16'h00FF, 16'h7FFF, 16'h0005, 16'hFFFF};
    tb = '{16'h0001, 16'h0001, 16'h0005, 16'h0000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{1'b0, 1'b0, 1'b1, 1'b0};
    texp = '{'{16'h0100, 1'b0, 1'b0, 1'b0},
             '{16'h8000, 1'b0, 1'b1, 1'b0},
             '{16'h0000, 1'b1, 1'b0, 1'b1},
             '{16'h0000, 1'b1, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, acc, emit);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL directed_accept[%0d]: got %b, want 1", i, acc);
      end
      lat  = 0;
      emit = 1'b0;
      while (!emit && lat < 8) begin
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, emit);
        lat++;
      end
      got = {sum, cout, ovf, zero};
      vectors++;
      if (lat !== STAGES) begin
        miscompares++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, STAGES);
      end
      vectors++;
      if (got !== texp[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_result[%0d]: got %h, want %h", i, got, texp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic             acc, emit, exp_ready, saw_stall_ready, prev_stall;
    res_t             got, prev, want;
    logic [WIDTH-1:0] xa, xb;
    logic             xc, xs, ordy;
    int               sent, rcvd;
    exp_q.delete();
    sent = 0;
    rcvd = 0;
    saw_stall_ready = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    for (int k = 0; k < 40 && rcvd < 6; k++) begin
      xa   = WIDTH'($urandom);
      xb   = WIDTH'($urandom);
      xc   = 1'($urandom);
      xs   = 1'($urandom);
      ordy = !(k >= 3 && k <= 5);
      drive_cycle(sent < 6, xa, xb, xc, xs, ordy, acc, emit);
      got = {sum, cout, ovf, zero};
      exp_ready = (exp_q.size() < STAGES) || ordy;
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL b2b_in_ready cycle %0d: got %b, want %b", k, in_ready, exp_ready);
      end
      if (!in_ready && sent < 6) saw_stall_ready = 1'b1;
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || got !== prev) begin
          miscompares++;
          $display("[TB] FAIL b2b_hold cycle %0d: got %b/%h, want 1/%h", k, out_valid, got, prev);
        end
      end
      if (emit) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL b2b_result beat %0d: got %h, want %h", rcvd, got, want);
        end
        rcvd++;
      end
      if (acc) begin
        exp_q.push_back(model(xa, xb, xc, xs));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = got;
    end
    vectors++;
    if (rcvd !== 6) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d, want 6", rcvd);
    end
    vectors++;
    if (saw_stall_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_backpressure: got %b, want 1", saw_stall_ready);
    end
  endtask

  task automatic test_reset_midflight;
    logic acc, emit;
    int   taken;
    exp_q.delete();
    taken = 0;
    for (int k = 0; k < 6 && taken < 2; k++) begin
      drive_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0, acc, emit);
      if (acc) taken++;
    end
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, emit);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midflight_loaded: got %b, want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midflight_async_clear: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, emit);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midflight_stale cycle %0d: got %b, want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic             acc, emit, exp_ready, prev_stall, ordy, iv, xc, xs;
    logic [WIDTH-1:0] corner[4];
    logic [WIDTH-1:0] xa, xb;
    res_t             got, prev, want;
    int               accepted, cycles;
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    exp_q.delete();
    accepted = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev = '0;
    while ((accepted < 10000 || exp_q.size() > 0) && cycles < 40000) begin
      iv   = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      ordy = (accepted >= 10000) || ($urandom_range(0, 3) != 0);
      xa   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      xb   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      xc   = 1'($urandom);
      xs   = 1'($urandom);
      drive_cycle(iv, xa, xb, xc, xs, ordy, acc, emit);
      got = {sum, cout, ovf, zero};
      exp_ready = (exp_q.size() < STAGES) || ordy;
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL rand_in_ready cycle %0d: got %b, want %b", cycles, in_ready, exp_ready);
      end
      if (exp_q.size() == 0) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_phantom cycle %0d: got %b, want 0", cycles, out_valid);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || got !== prev) begin
          miscompares++;
          $display("[TB] FAIL rand_hold cycle %0d: got %b/%h, want 1/%h", cycles, out_valid, got, prev);
        end
      end
      if (emit) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("[TB] FAIL rand_result cycle %0d: got %h, want %h", cycles, got, want);
        end
      end
      if (acc) begin
        exp_q.push_back(model(xa, xb, xc, xs));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev = got;
      cycles++;
    end
    vectors++;
    if (accepted !== 10000 || exp_q.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL rand_complete: got %0d accepted/%0d pending, want 10000/0",
               accepted, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
